seq_alu: RTL
============

Name: seq_alu

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Operands are accepted through a valid/ready handshake. Multiply, divide and remainder run iteratively over WIDTH cycles; every other operation completes in one cycle.
- Result and flags are held in output registers until the consumer accepts them.
- Sits between the register file/decoder and the writeback/flags register of the processor datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥ 4.
- SHW, $clog2(WIDTH), width of the shift-amount field taken from B[SHW-1:0]; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept a new operation.
- Selector  input  8  opcode; same encoding as the existing ALU (0x01..0x0F).
- A  input  WIDTH  operand A (dividend, shift source).
- B  input  WIDTH  operand B (divisor, shift amount).
- out_valid  output  1  X/Flags hold a completed result.
- out_ready  input  1  consumer accepts the result.
- X  output  WIDTH  result.
- Flags  output  8  bit0 Z, bit1 C, bit2 S, bit3 P, bit6 O, bit7 DZ (divide by zero); bits 4–5 always 0.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, in_ready=1, out_valid=0, X=0, Flags=0, internal counters/accumulators cleared. Reset asserted mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Operands and opcode are captured on an edge where in_valid=1.
    - Mul/div/rem opcode → BUSY, iteration counter = WIDTH.
    - Any other opcode → DONE, with result computed and registered on that same edge.
  - BUSY: in_ready=0. One shift-add / restoring-subtract step per cycle; counter decrements. At counter=1 the final result and flags are registered → DONE.
  - DONE: out_valid=1, in_ready=0. X/Flags stay stable. out_ready=1 → IDLE. No new operation is accepted in the same cycle (no bypass).
- Latency from accept edge to out_valid=1:
  - 1 cycle for single-cycle operations.
  - WIDTH cycles for mul/div/rem.
- Throughput: at most one operation in flight. Operands are sampled only at accept; changing A/B while BUSY has no effect.
- Arithmetic (unsigned datapath, WIDTH bits):
  - 0x01 ADD: C = carry out; O = A[MSB]==B[MSB] && X[MSB]!=A[MSB].
  - 0x02 SUB: X = A−B mod 2^WIDTH; C = borrow (A<B); O = A[MSB]!=B[MSB] && X[MSB]!=A[MSB].
  - 0x03 MUL: X = low half of product; C = O = (high half != 0).
  - 0x04 DIV → quotient; 0x05 REM → remainder.
  - B=0 for DIV/REM: DZ=1, quotient = all ones, remainder = A. Still takes WIDTH cycles.
  - 0x06–0x0C: AND, OR, XOR, NAND, NOR, XNOR, NOT A. C=O=0.
  - 0x0D SHL / 0x0E SHR (logical) by B[SHW-1:0]. C = last bit shifted out; C=0 for a shift of 0.
  - 0x0F CMP: X[0]=equal, X[1]=A>B, X[2]=A<B, other bits 0. Flags[0..2] mirror X[0..2]; all other flags 0.
- Flags for every opcode except CMP: Z = (X==0); S = X[MSB]; P = XNOR-reduce of X (1 = even number of ones).
- Undefined opcode: single cycle, X=0, Flags=0.

Optional Feature:
- Macro ALU_WIDE_RESULT_EN.
- Defined: adds output port X_hi (WIDTH bits).
  - MUL: X_hi = high half of product.
  - DIV/REM: X_hi = remainder and quotient respectively, so both are obtained in one operation.
  - All other opcodes: X_hi = 0.
  - Reset value 0; held alongside X.
- Undefined: port and its registers are absent; behaviour otherwise identical.

Decomposition:
- Package alu_pkg:
  - opcode localparams (OP_ADD..OP_CMP);
  - flag bit indices (FLG_Z, FLG_C, FLG_S, FLG_P, FLG_O, FLG_DZ);
  - FSM state encoding.
- Sub-module alu_iter_muldiv: shared WIDTH-cycle shift-add multiplier / restoring divider with start/done and mode inputs. The top level keeps the FSM, single-cycle ops and flag generation.

Test Plan (WIDTH=8):
- ADD A=0x7F B=0x01 → out_valid 1 cycle after accept, X=0x80, Flags=0x44.
- SUB A=0x05 B=0x05 → X=0x00, Flags=0x09. SUB A=0x00 B=0x01 → X=0xFF, Flags=0x0E.
- MUL A=0x10 B=0x10 → out_valid 8 cycles after accept, X=0x00, Flags=0x4B; with ALU_WIDE_RESULT_EN, X_hi=0x01.
- DIV A=0x64 B=0x07 → X=0x0E, Flags=0x00. REM same operands → X=0x02, Flags=0x00. DIV A=0x2A B=0x00 → X=0xFF, Flags=0x8C.
- Backpressure: ADD result held with out_ready=0 for 3 cycles → X/Flags stable, in_ready=0, a new in_valid is ignored; out_ready=1 → in_ready=1 next cycle.
- Reset mid-division (rst_n low at cycle 4 of BUSY) → immediately out_valid=0, X=0, Flags=0; after release in_ready=1 and a fresh ADD completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag-bit and FSM-state definitions shared by seq_alu
package alu_pkg;
   localparam logic [7:0] OP_ADD  = 8'h01;
   localparam logic [7:0] OP_SUB  = 8'h02;
   localparam logic [7:0] OP_MUL  = 8'h03;
   localparam logic [7:0] OP_DIV  = 8'h04;
   localparam logic [7:0] OP_REM  = 8'h05;
   localparam logic [7:0] OP_AND  = 8'h06;
   localparam logic [7:0] OP_OR   = 8'h07;
   localparam logic [7:0] OP_XOR  = 8'h08;
   localparam logic [7:0] OP_NAND = 8'h09;
   localparam logic [7:0] OP_NOR  = 8'h0A;
   localparam logic [7:0] OP_XNOR = 8'h0B;
   localparam logic [7:0] OP_NOT  = 8'h0C;
   localparam logic [7:0] OP_SHL  = 8'h0D;
   localparam logic [7:0] OP_SHR  = 8'h0E;
   localparam logic [7:0] OP_CMP  = 8'h0F;

   localparam int FLG_Z  = 0;
   localparam int FLG_C  = 1;
   localparam int FLG_S  = 2;
   localparam int FLG_P  = 3;
   localparam int FLG_O  = 6;
   localparam int FLG_DZ = 7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - iterative shift-add multiplier / restoring divider, one step per clock
// The first step runs on the start edge from the raw operands, so WIDTH steps finish WIDTH-1 edges later.
module alu_iter_muldiv #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] hi_r, lo_r, opnd_r;
   logic             mode_r;
   logic [CW-1:0]    cnt_r;

   logic             running;
   logic             cur_mode;
   logic [WIDTH-1:0] cur_hi, cur_lo, cur_opnd;
   logic [WIDTH:0]   sum, shifted;
   logic [WIDTH-1:0] diff;

   assign running  = (cnt_r != '0);
   assign done     = running && (cnt_r == CW'(1));
   assign cur_mode = start ? div_mode : mode_r;
   assign cur_hi   = start ? '0 : hi_r;
   assign cur_lo   = start ? (div_mode ? a : b) : lo_r;
   assign cur_opnd = start ? (div_mode ? b : a) : opnd_r;

   // Multiply: hi:lo is partial product : remaining multiplier bits.
   // Divide: hi:lo is partial remainder : dividend bits shifting into quotient.
   always_comb begin
      sum     = {1'b0, cur_hi} + {1'b0, cur_opnd};
      shifted = {cur_hi, cur_lo[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - cur_opnd;
      nxt_hi  = cur_hi;
      nxt_lo  = cur_lo;
      if (cur_mode) begin
         if (shifted >= {1'b0, cur_opnd}) begin
            nxt_hi = diff;
            nxt_lo = {cur_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {cur_lo[WIDTH-2:0], 1'b0};
         end
      end else if (cur_lo[0]) begin
         {nxt_hi, nxt_lo} = {sum, cur_lo[WIDTH-1:1]};
      end else begin
         {nxt_hi, nxt_lo} = {1'b0, cur_hi, cur_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r   <= '0;
         lo_r   <= '0;
         opnd_r <= '0;
         mode_r <= 1'b0;
         cnt_r  <= '0;
      end else if (start || running) begin
         hi_r   <= nxt_hi;
         lo_r   <= nxt_lo;
         opnd_r <= cur_opnd;
         mode_r <= cur_mode;
         cnt_r  <= start ? CW'(WIDTH - 1) : cnt_r - CW'(1);
      end
   end
endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered handshake ALU with iterative mul/div/rem
// Optional X_hi output (high product half / companion div result) enabled by ALU_WIDE_RESULT_EN.
module seq_alu
   import alu_pkg::*;
#(
   parameter int  WIDTH = 8,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       Selector,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] X,
   output logic [7:0]       Flags
`ifdef ALU_WIDE_RESULT_EN
   ,
   output logic [WIDTH-1:0] X_hi
`endif
);
   state_t           state, state_nxt;
   logic [7:0]       op_r, op;
   logic             bz_r;
   logic             accept, is_md, md_done;
   logic [WIDTH-1:0] md_hi, md_lo;
   logic [WIDTH-1:0] res_x;
   logic             res_c, res_o, res_dz;
   logic [7:0]       res_f;
   logic [SHW-1:0]   sh;

   assign accept = (state == ST_IDLE) && in_valid;
   assign is_md  = (Selector == OP_MUL) || (Selector == OP_DIV) || (Selector == OP_REM);
   assign op     = (state == ST_BUSY) ? op_r : Selector;
   assign sh     = B[SHW-1:0];

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept && is_md),
      .div_mode (Selector != OP_MUL),
      .a        (A),
      .b        (B),
      .done     (md_done),
      .nxt_hi   (md_hi),
      .nxt_lo   (md_lo)
   );

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = is_md ? ST_BUSY : ST_DONE;
         end
         ST_BUSY: if (md_done) state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      res_x  = '0;
      res_c  = 1'b0;
      res_o  = 1'b0;
      res_dz = 1'b0;
      case (op)
         OP_ADD: begin
            {res_c, res_x} = {1'b0, A} + {1'b0, B};
            res_o = (A[WIDTH-1] == B[WIDTH-1]) && (res_x[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            {res_c, res_x} = {1'b0, A} - {1'b0, B};
            res_o = (A[WIDTH-1] != B[WIDTH-1]) && (res_x[WIDTH-1] != A[WIDTH-1]);
         end
         OP_MUL: begin
            res_x = md_lo;
            res_c = |md_hi;
            res_o = |md_hi;
         end
         OP_DIV: begin
            res_x  = md_lo;
            res_dz = bz_r;
         end
         OP_REM: begin
            res_x  = md_hi;
            res_dz = bz_r;
         end
         OP_AND:  res_x = A & B;
         OP_OR:   res_x = A | B;
         OP_XOR:  res_x = A ^ B;
         OP_NAND: res_x = ~(A & B);
         OP_NOR:  res_x = ~(A | B);
         OP_XNOR: res_x = ~(A ^ B);
         OP_NOT:  res_x = ~A;
         // The extra guard bit catches the last bit shifted out; it stays 0 for a zero shift.
         OP_SHL:  {res_c, res_x} = {1'b0, A} << sh;
         OP_SHR:  {res_x, res_c} = {A, 1'b0} >> sh;
         OP_CMP: begin
            res_x[0] = (A == B);
            res_x[1] = (A > B);
            res_x[2] = (A < B);
         end
         default: ;
      endcase

      res_f = '0;
      if (op >= OP_ADD && op <= OP_SHR) begin
         res_f[FLG_Z]  = (res_x == '0);
         res_f[FLG_C]  = res_c;
         res_f[FLG_S]  = res_x[WIDTH-1];
         res_f[FLG_P]  = ~^res_x;
         res_f[FLG_O]  = res_o;
         res_f[FLG_DZ] = res_dz;
      end else if (op == OP_CMP) begin
         res_f[2:0] = res_x[2:0];
      end
   end

`ifdef ALU_WIDE_RESULT_EN
   logic [WIDTH-1:0] res_hi;

   always_comb begin
      res_hi = '0;
      case (op)
         OP_MUL:  res_hi = md_hi;
         OP_DIV:  res_hi = md_hi;
         OP_REM:  res_hi = md_lo;
         default: res_hi = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) X_hi <= '0;
      else if ((accept && !is_md) || md_done) X_hi <= res_hi;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         op_r  <= '0;
         bz_r  <= 1'b0;
         X     <= '0;
         Flags <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_r <= Selector;
            bz_r <= (B == '0);
         end
         if ((accept && !is_md) || md_done) begin
            X     <= res_x;
            Flags <= res_f;
         end
      end
   end
endmodule
